// File: rtl/worley_point_animator.sv
// Feature-point animator for the Worley noise generator: moves 4 points with
// constant velocity and edge bounce during vblank, then commits them atomically.
module worley_point_animator #(
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned Y_MAX     = 479,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    output logic [39:0] points_x,
    output logic [39:0] points_y,
    output logic        busy,
    output logic        update_done,
    output logic [19:0] frame_count
);

    localparam int unsigned NPTS  = 4;
    localparam int unsigned CW    = 10;
    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [CW-1:0]     INIT_X  [NPTS] = '{10'd100, 10'd300, 10'd500, 10'd100};
    localparam logic [CW-1:0]     INIT_Y  [NPTS] = '{10'd100, 10'd200, 10'd400, 10'd460};
    localparam logic signed [2:0] INIT_VX [NPTS] = '{3'sd1, -3'sd1, 3'sd2, -3'sd1};
    localparam logic signed [2:0] INIT_VY [NPTS] = '{-3'sd1, 3'sd1, -3'sd1, -3'sd2};

    typedef enum logic [1:0] {
        IDLE,
        UPD,
        COMMIT
    } state_t;

    state_t              state_q;
    logic [1:0]          idx_q;
    logic [DIV_W-1:0]    div_q;
    logic [CW-1:0]       wx_q [NPTS];
    logic [CW-1:0]       wy_q [NPTS];
    logic signed [2:0]   vx_q [NPTS];
    logic signed [2:0]   vy_q [NPTS];
    logic [39:0]         points_x_q;
    logic [39:0]         points_y_q;
    logic                busy_q;
    logic                update_done_q;
    logic [19:0]         frame_count_q;

    logic [CW:0]         step_x_d;
    logic [CW:0]         step_y_d;

    // One axis step; returns {velocity_flip, new_position}.
    function automatic logic [CW:0] axis_step(input logic [CW-1:0] p,
                                              input logic signed [2:0] v,
                                              input int unsigned lim);
        logic signed [12:0] s;
        logic signed [12:0] m;
        logic signed [12:0] r;
        logic               flip;
        s    = $signed({3'b000, p}) + 13'(v);
        m    = $signed(13'(lim));
        flip = 1'b0;
        if (v > 3'sd0 && s > m) begin
            r    = (m <<< 1) - s;
            flip = 1'b1;
        end else if (v < 3'sd0 && s < 13'sd0) begin
            r    = -s;
            flip = 1'b1;
        end else begin
            r = s;
        end
        return {flip, r[CW-1:0]};
    endfunction

    always_comb begin
        step_x_d = axis_step(wx_q[idx_q], vx_q[idx_q], X_MAX);
        step_y_d = axis_step(wy_q[idx_q], vy_q[idx_q], Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            div_q         <= '0;
            busy_q        <= 1'b0;
            update_done_q <= 1'b0;
            frame_count_q <= 20'd0;
            for (int i = 0; i < NPTS; i++) begin
                wx_q[i]                <= INIT_X[i];
                wy_q[i]                <= INIT_Y[i];
                vx_q[i]                <= INIT_VX[i];
                vy_q[i]                <= INIT_VY[i];
                points_x_q[CW*i +: CW] <= INIT_X[i];
                points_y_q[CW*i +: CW] <= INIT_Y[i];
            end
        end else begin
            update_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Only pulses seen while idle count toward the frame divider.
                    if (frame_start && enable) begin
                        if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                            div_q   <= '0;
                            idx_q   <= 2'd0;
                            state_q <= UPD;
                            busy_q  <= 1'b1;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                end
                UPD: begin
                    wx_q[idx_q] <= step_x_d[CW-1:0];
                    wy_q[idx_q] <= step_y_d[CW-1:0];
                    if (step_x_d[CW]) vx_q[idx_q] <= -vx_q[idx_q];
                    if (step_y_d[CW]) vy_q[idx_q] <= -vy_q[idx_q];
                    if (idx_q == 2'd3) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NPTS; i++) begin
                        points_x_q[CW*i +: CW] <= wx_q[i];
                        points_y_q[CW*i +: CW] <= wy_q[i];
                    end
                    update_done_q <= 1'b1;
                    frame_count_q <= frame_count_q + 20'd1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign points_x    = points_x_q;
    assign points_y    = points_y_q;
    assign busy        = busy_q;
    assign update_done = update_done_q;
    assign frame_count = frame_count_q;

endmodule
